// File: rtl/bilinear_resize_core.sv
// Bilinear resize consumer: walks destination pixels in Q11.FRAC_W source space, reads 2x2
// neighbourhoods from the line buffer and emits RGB888. Define RESIZE_NEAREST_EN for nearest-neighbour.
module bilinear_resize_core #(
  parameter int FRAC_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [10:0]        src_width,
  input  logic [10:0]        src_height,
  input  logic [10:0]        dst_width,
  input  logic [10:0]        dst_height,
  input  logic [FRAC_W+10:0] x_step,
  input  logic [FRAC_W+10:0] y_step,
  input  logic               lb_rd_ready,
  output logic               lb_rd_en,
  output logic [10:0]        lb_rd_addr,
  output logic               lb_rd_finish,
  input  logic               lb_valid,
  input  logic [47:0]        lb_cur_line,
  input  logic [47:0]        lb_next_line,
  output logic               valid_o,
  output logic [23:0]        data_o,
  output logic               last_o,
  output logic               frame_done
);

  // state     | meaning
  // IDLE      | waiting for start
  // WAIT_LINE | waiting for the buffer to hold the needed line pair
  // RD_ROW    | one read per destination pixel of the current row
  // NEXT_ROW  | advance vertical accumulator and row counter
  // RELEASE   | release one source line, then one idle cycle
  // DRAIN     | release remaining lines, wait for the pipeline to empty
  // DONE      | frame_done pulse
  typedef enum logic [2:0] {IDLE, WAIT_LINE, RD_ROW, NEXT_ROW, RELEASE, DRAIN, DONE} state_t;

  localparam int ACC_W = FRAC_W + 12;
  localparam int W_W   = FRAC_W + 1;
  localparam int T_W   = FRAC_W + 9;
  localparam int S_W   = 2 * FRAC_W + 9;
  localparam logic [W_W-1:0] W_ONE  = {1'b1, {FRAC_W{1'b0}}};
  localparam logic [W_W-1:0] W_HALF = {2'b01, {(FRAC_W-1){1'b0}}};

  state_t              state, state_nx;
  logic [10:0]         src_w, src_h, dst_w, dst_h;
  logic [FRAC_W+10:0]  xs, ys;
  logic [ACC_W-1:0]    sx_acc, sy_acc;
  logic [10:0]         k, row_cnt, col_cnt;
  logic                tmr;
  logic [10+W_W:0]     row_map, col_map;
  logic [10:0]         row_idx, col_idx;
  logic [W_W-1:0]      fx_w, fy_w;
  logic                col_last, row_last, pipe_busy;

  logic                p1_v, p2_v, p1_last, p2_last, s1_v, s1_last;
  logic [W_W-1:0]      p1_fx, p1_fy, p2_fx, p2_fy;
  logic [23:0]         res_nx;

  // Past the last interior pair, sit on the final pair with full weight on the far pixel.
  function automatic logic [10+W_W:0] map_coord(input logic [ACC_W-1:0] acc, input logic [10:0] size);
    logic [11:0] ip;
    ip = acc[ACC_W-1:FRAC_W];
    if (ip >= {1'b0, size} - 12'd1) map_coord = {size - 11'd2, W_ONE};
    else                            map_coord = {ip[10:0], 1'b0, acc[FRAC_W-1:0]};
  endfunction

  assign row_map   = map_coord(sy_acc, src_h);
  assign col_map   = map_coord(sx_acc, src_w);
  assign row_idx   = row_map[10+W_W:W_W];
  assign fy_w      = row_map[W_W-1:0];
  assign col_idx   = col_map[10+W_W:W_W];
  assign fx_w      = col_map[W_W-1:0];
  assign col_last  = (col_cnt == dst_w - 11'd1);
  assign row_last  = (row_cnt == dst_h - 11'd1);
  assign pipe_busy = p1_v | p2_v | s1_v | valid_o;

  always_comb begin
    state_nx     = state;
    lb_rd_en     = 1'b0;
    lb_rd_addr   = 11'd0;
    lb_rd_finish = 1'b0;
    frame_done   = 1'b0;
    case (state)
      IDLE:      if (start) state_nx = WAIT_LINE;
      WAIT_LINE: if (lb_rd_ready) state_nx = (row_idx > k) ? RELEASE : RD_ROW;
      RELEASE: begin
        lb_rd_finish = tmr;
        if (!tmr) state_nx = WAIT_LINE;
      end
      RD_ROW: begin
        lb_rd_en   = 1'b1;
        lb_rd_addr = col_idx;
        if (col_last) state_nx = NEXT_ROW;
      end
      NEXT_ROW:  state_nx = row_last ? DRAIN : WAIT_LINE;
      DRAIN: begin
        if (k < src_h) lb_rd_finish = !tmr;
        else if (!pipe_busy) state_nx = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nx   = IDLE;
      end
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      src_w   <= '0;
      src_h   <= '0;
      dst_w   <= '0;
      dst_h   <= '0;
      xs      <= '0;
      ys      <= '0;
      sx_acc  <= '0;
      sy_acc  <= '0;
      k       <= '0;
      row_cnt <= '0;
      col_cnt <= '0;
      tmr     <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        src_w   <= src_width;
        src_h   <= src_height;
        dst_w   <= dst_width;
        dst_h   <= dst_height;
        xs      <= x_step;
        ys      <= y_step;
        sx_acc  <= '0;
        sy_acc  <= '0;
        k       <= '0;
        row_cnt <= '0;
        col_cnt <= '0;
      end
      if (lb_rd_en) begin
        sx_acc  <= sx_acc + {1'b0, xs};
        col_cnt <= col_cnt + 11'd1;
      end
      if (state == NEXT_ROW) begin
        sy_acc  <= sy_acc + {1'b0, ys};
        sx_acc  <= '0;
        col_cnt <= '0;
        row_cnt <= row_cnt + 11'd1;
      end
      if (lb_rd_finish) k <= k + 11'd1;
      // Gap timer: the idle cycle after a release, and the spacing of drain pulses.
      if ((state == WAIT_LINE && state_nx == RELEASE) || (state == DRAIN && lb_rd_finish))
        tmr <= 1'b1;
      else if (tmr)
        tmr <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_v    <= 1'b0;
      p1_fx   <= '0;
      p1_fy   <= '0;
      p1_last <= 1'b0;
      p2_v    <= 1'b0;
      p2_fx   <= '0;
      p2_fy   <= '0;
      p2_last <= 1'b0;
      s1_v    <= 1'b0;
      s1_last <= 1'b0;
      valid_o <= 1'b0;
      last_o  <= 1'b0;
      data_o  <= '0;
    end else begin
      p1_v    <= lb_rd_en;
      p1_fx   <= fx_w;
      p1_fy   <= fy_w;
      p1_last <= col_last;
      p2_v    <= p1_v;
      p2_fx   <= p1_fx;
      p2_fy   <= p1_fy;
      p2_last <= p1_last;
      s1_v    <= lb_valid;
      s1_last <= p2_last;
      valid_o <= s1_v;
      last_o  <= s1_v & s1_last;
      if (s1_v) data_o <= res_nx;
    end
  end

`ifdef RESIZE_NEAREST_EN
  logic [47:0] near_row;
  logic [23:0] near_nx, s1_pix;

  always_comb begin
    near_row = (p2_fy >= W_HALF) ? lb_next_line : lb_cur_line;
    near_nx  = (p2_fx >= W_HALF) ? near_row[23:0] : near_row[47:24];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s1_pix <= '0;
    else          s1_pix <= near_nx;
  end

  assign res_nx = s1_pix;
`else
  logic [T_W-1:0] top_nx [3];
  logic [T_W-1:0] bot_nx [3];
  logic [T_W-1:0] s1_top [3];
  logic [T_W-1:0] s1_bot [3];
  logic [W_W-1:0] s1_fy;
  localparam logic [S_W-1:0] RND = S_W'(1) << (2 * FRAC_W - 1);

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      top_nx[c] = T_W'(lb_cur_line[24+8*c +: 8]) * T_W'(W_ONE - p2_fx)
                + T_W'(lb_cur_line[8*c +: 8]) * T_W'(p2_fx);
      bot_nx[c] = T_W'(lb_next_line[24+8*c +: 8]) * T_W'(W_ONE - p2_fx)
                + T_W'(lb_next_line[8*c +: 8]) * T_W'(p2_fx);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < 3; c++) begin
        s1_top[c] <= '0;
        s1_bot[c] <= '0;
      end
      s1_fy <= '0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        s1_top[c] <= top_nx[c];
        s1_bot[c] <= bot_nx[c];
      end
      s1_fy <= p2_fy;
    end
  end

  // Weights sum to 2^FRAC_W per axis, so the rounded result always fits 8 bits.
  always_comb begin
    res_nx = '0;
    for (int c = 0; c < 3; c++)
      res_nx[8*c +: 8] = 8'((S_W'(s1_top[c]) * S_W'(W_ONE - s1_fy)
                           + S_W'(s1_bot[c]) * S_W'(s1_fy) + RND) >> (2 * FRAC_W));
  end
`endif

endmodule

// File: doc/bilinear_resize_core.md
# bilinear_resize_core

Downstream consumer of the three-line image line buffer in the bilinear resize path. It walks destination coordinates in fixed-point source space and drives the buffer's read handshake (`rd_en`/`rd_addr`/`rd_finish`). It interpolates the returned 2×2 pixel neighbourhood into one RGB888 output pixel per destination coordinate and releases consumed source lines back to the buffer.

## Interface
- `FRAC_W`, 8: fractional bits of step and accumulators; weights span 0..2^FRAC_W.
- `clk` in 1: single clock; all logic rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: pulse; begins a frame when IDLE, ignored otherwise.
- `src_width`, `src_height` in 11 each: source size, each ≥2; sampled on start.
- `dst_width`, `dst_height` in 11 each: destination size, each ≥1; sampled on start.
- `x_step`, `y_step` in 19 each: unsigned Q11.8 source/destination ratio; sampled on start.
- `lb_rd_ready` in 1: line buffer holds a current/next line pair.
- `lb_rd_en` out 1: read strobe.
- `lb_rd_addr` out 11: word address = left-pixel column.
- `lb_rd_finish` out 1: one-cycle pulse, releases the current source line.
- `lb_valid` in 1: read data valid, 2 cycles after `lb_rd_en`.
- `lb_cur_line` in 48: {P(x), P(x+1)} of upper row, P(x) in [47:24].
- `lb_next_line` in 48: same for lower row.
- `valid_o` out 1; `data_o` out 24 {R,G,B}; `last_o` out 1 (last pixel of a destination row).
- `frame_done` out 1: one-cycle pulse after the final release of a frame.

## Operation
- FSM states: IDLE, WAIT_LINE, RD_ROW, NEXT_ROW, RELEASE, DRAIN, DONE.
- `k` = index of the buffer's current source line; `sy_acc`/`sx_acc` are 20-bit accumulators of `y_step`/`x_step`, both cleared on start.
- Row mapping: `sy_int = sy_acc >> 8`, `fy = sy_acc[7:0]`. If `sy_int ≥ src_height-1`, treat as row `src_height-2` with `fy = 256` (9-bit weight). Column mapping is identical with `src_width`.
- WAIT_LINE: when `lb_rd_ready` is high, go to RELEASE if target row > `k`, otherwise go to RD_ROW.
- RELEASE: drive one `lb_rd_finish` pulse, increment `k`, then spend one idle cycle before returning to WAIT_LINE, because buffer status is registered.
- RD_ROW: `lb_rd_en=1` for `dst_width` consecutive cycles with `lb_rd_addr = clamped sx_int`. Per-pixel `fx`, `fy` and last flags travel in a 2-deep shift register aligned to `lb_valid`.
- NEXT_ROW: add `y_step`, clear `sx_acc`, increment the row counter. After the last row go to DRAIN, otherwise go to WAIT_LINE.
- DRAIN: pulse `lb_rd_finish` for lines `k..src_height-1`, pulses spaced 2 cycles apart, so every source line of the frame is released exactly once. Go to DONE after the last output pixel.
- DONE: `frame_done` pulse, then IDLE.
- Interpolation per 8-bit channel:
  - Stage 1: `top = P00·(256-fx) + P01·fx` and `bot = P10·(256-fx) + P11·fx`, 17 bits each.
  - Stage 2: `(top·(256-fy) + bot·fy + 2^15) >> 16`, 25-bit intermediate.
  - Result fits 8 bits with no saturation. `data_o` is registered.

## Timing
- Reset values: `lb_rd_en`=0, `lb_rd_addr`=0, `lb_rd_finish`=0, `valid_o`=0, `data_o`=0, `last_o`=0, `frame_done`=0, state IDLE, `k`=0.
- Latency: `lb_valid` → `valid_o` is 2 cycles; `lb_rd_en` → `valid_o` is 4 cycles. Throughput is 1 pixel/cycle within a row.
- No downstream backpressure: the consumer must accept every cycle `valid_o` is high.
- `lb_rd_en` and `lb_rd_finish` are never high in the same cycle. `lb_rd_finish` is never issued while reads of the current pair remain in flight; there are ≥2 cycles after the last `lb_rd_en`.
- Downscale with `y_step > 256` releases multiple lines consecutively, each followed by a `lb_rd_ready` wait.
- `start` during a frame is ignored.
- Reset asserted mid-frame clears all state immediately. Outputs go to reset values without completing the frame.

## Configuration
- `RESIZE_NEAREST_EN` defined: the interpolator is replaced by nearest-neighbour selection.
  - Column: `fx ≥ 128` selects the right pixel, otherwise the left.
  - Row: `fy ≥ 128` selects `lb_next_line`, otherwise `lb_cur_line`.
  - Same 2-cycle latency and identical handshake.
- Not defined: bilinear datapath as above.

## Test plan
- Identity: 4×4→4×4, steps 256, pixel value = 16·row + col on all channels. Required: output equals input exactly; 4 `last_o` pulses; 4 `lb_rd_finish` total; one `frame_done`.
- 2× upscale: src 4×4 with row 0 = {0,100,200,250}, dst 8×8, steps 128. Required: output row 0 = 0,50,100,150,200,225,250,250.
- Vertical blend: rows all 0 / all 200, `y_step` = 64. Required: outputs 0, 50, 100, 150 for `fy` = 0, 64, 128, 192.
- Downscale: 8×8→4×4, steps 512. Required: source lines released in pairs; output = pixels (2i, 2j); 8 total releases.
- Hold `lb_rd_ready` low 20 cycles mid-frame. Required: no `lb_rd_en` while low; output resumes correctly.
- Assert `reset_n`=0 mid-row. Required: all outputs 0 the same cycle. A subsequent start produces a correct full frame.
- With `RESIZE_NEAREST_EN`, rerun the 2× upscale. Required: row 0 = 0,100,100,200,200,250,250,250.
